// File: rtl/nbit_piso_serializer.sv
// Parallel-in serial-out word serializer, LSB first, advancing one bit per
// shared-slot tick (global_counter == 15).
module nbit_piso_serializer #(
  parameter int N = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [4:0]               global_counter,
  input  logic                     load_valid,
  input  logic [N-1:0]             load_data,
  output logic                     load_ready,
  output logic                     serial_out,
  output logic                     serial_valid,
  output logic [$clog2(N+1)-1:0]   bits_sent,
  output logic                     word_done
);

  localparam int              BW   = $clog2(N+1);
  localparam logic [4:0]      TICK = 5'd15;
  localparam logic [BW-1:0]   LAST = BW'(N - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  shreg_q, shreg_d;
  logic [BW-1:0] bits_sent_q, bits_sent_d;
  logic          serial_valid_q, serial_valid_d;
  logic          load_ready_q, load_ready_d;
  logic          word_done_q, word_done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      shreg_q        <= '0;
      bits_sent_q    <= '0;
      serial_valid_q <= 1'b0;
      load_ready_q   <= 1'b1;
      word_done_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      shreg_q        <= shreg_d;
      bits_sent_q    <= bits_sent_d;
      serial_valid_q <= serial_valid_d;
      load_ready_q   <= load_ready_d;
      word_done_q    <= word_done_d;
    end
  end

  // Bit 0 of the shift register is the serial line; it is cleared whenever
  // the block is idle so serial_out reads 0 there without a separate flop.
  always_comb begin
    state_d        = state_q;
    shreg_d        = shreg_q;
    bits_sent_d    = bits_sent_q;
    serial_valid_d = serial_valid_q;
    load_ready_d   = load_ready_q;
    word_done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        bits_sent_d    = '0;
        serial_valid_d = 1'b0;
        load_ready_d   = 1'b1;
        if (load_valid) begin
          state_d        = SHIFT;
          shreg_d        = load_data;
          serial_valid_d = 1'b1;
          load_ready_d   = 1'b0;
        end
      end

      SHIFT: begin
        if (global_counter == TICK) begin
          shreg_d     = {1'b0, shreg_q[N-1:1]};
          bits_sent_d = bits_sent_q + BW'(1);
          // bits_sent shows N for the word_done cycle, then drops to 0.
          if (bits_sent_q == LAST) begin
            state_d        = IDLE;
            shreg_d        = '0;
            serial_valid_d = 1'b0;
            load_ready_d   = 1'b1;
            word_done_d    = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign load_ready   = load_ready_q;
  assign serial_out   = shreg_q[0];
  assign serial_valid = serial_valid_q;
  assign bits_sent    = bits_sent_q;
  assign word_done    = word_done_q;

endmodule
